// File: rtl/window_addr_router.sv
// Conv-window address router: walks a feature map in input SRAM (oy, ox, ky, kx, ch order)
// and streams the read words with window/frame tags through an output FIFO.
module window_addr_router #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_reg_clear,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [ADDR_WIDTH-1:0] i_i_size,
    input  logic [ADDR_WIDTH-1:0] i_o_size,
    input  logic [ADDR_WIDTH-1:0] i_stride,
    input  logic [ADDR_WIDTH-1:0] i_k_size,
    input  logic [ADDR_WIDTH-1:0] i_ch_count,
    output logic                  o_sram_rd_en,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    input  logic [DATA_WIDTH-1:0] i_sram_rd_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_win_last,
    output logic                  o_frame_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_cfg_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_ERR   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Bounds are stored as max index; strides are pre-multiplied into word units.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] k_max;
        logic [ADDR_WIDTH-1:0] o_max;
        logic [ADDR_WIDTH-1:0] ch_max;
        logic [ADDR_WIDTH-1:0] ch_words;
        logic [ADDR_WIDTH-1:0] row_words;
        logic [ADDR_WIDTH-1:0] stride_words;
        logic [ADDR_WIDTH-1:0] line_step;
        logic                  err;
    } cfg_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] oy;
        logic [ADDR_WIDTH-1:0] ox;
        logic [ADDR_WIDTH-1:0] ky;
        logic [ADDR_WIDTH-1:0] kx;
        logic [ADDR_WIDTH-1:0] ch;
        logic [ADDR_WIDTH-1:0] line;
        logic [ADDR_WIDTH-1:0] win;
        logic [ADDR_WIDTH-1:0] row;
        logic [ADDR_WIDTH-1:0] pix;
        logic [ADDR_WIDTH-1:0] addr;
    } cnt_t;

    state_t          state_q, state_d;
    cfg_t            cfg_q, cfg_d;
    cnt_t            cnt_q, cnt_d;
    logic            inflight_q, inflight_d;
    logic            wl_pipe_q, wl_pipe_d;
    logic            fl_pipe_q, fl_pipe_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [EW-1:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            rd_fire_s;
    logic            credit_ok_s;
    logic            wl_s;
    logic            fl_s;
    logic            push_s;
    logic            pop_s;

    assign credit_ok_s = (count_q + CW'(inflight_q)) < CW'(FIFO_DEPTH);
    assign wl_s = (cnt_q.ky == cfg_q.k_max) && (cnt_q.kx == cfg_q.k_max) &&
                  (cnt_q.ch == cfg_q.ch_max);
    assign fl_s = wl_s && (cnt_q.oy == cfg_q.o_max) && (cnt_q.ox == cfg_q.o_max);

    // Control FSM, config capture and incremental address walker.
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        cnt_d     = cnt_q;
        rd_fire_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    cfg_d.k_max        = i_k_size - ADDR_WIDTH'(1);
                    cfg_d.o_max        = i_o_size - ADDR_WIDTH'(1);
                    cfg_d.ch_max       = i_ch_count - ADDR_WIDTH'(1);
                    cfg_d.ch_words     = i_ch_count;
                    cfg_d.row_words    = i_i_size * i_ch_count;
                    cfg_d.stride_words = i_stride * i_ch_count;
                    cfg_d.line_step    = i_stride * i_i_size * i_ch_count;
                    cfg_d.err          = (i_k_size == '0) || (i_stride == '0) ||
                                         (i_o_size == '0) || (i_ch_count == '0);
                    cnt_d      = '0;
                    cnt_d.line = i_start_addr;
                    cnt_d.win  = i_start_addr;
                    cnt_d.row  = i_start_addr;
                    cnt_d.pix  = i_start_addr;
                    cnt_d.addr = i_start_addr;
                    state_d    = cfg_d.err ? S_ERR : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (credit_ok_s) begin
                    rd_fire_s = 1'b1;
                    if (cnt_q.ch != cfg_q.ch_max) begin
                        cnt_d.ch   = cnt_q.ch + ADDR_WIDTH'(1);
                        cnt_d.addr = cnt_q.addr + ADDR_WIDTH'(1);
                    end else if (cnt_q.kx != cfg_q.k_max) begin
                        cnt_d.ch   = '0;
                        cnt_d.kx   = cnt_q.kx + ADDR_WIDTH'(1);
                        cnt_d.pix  = cnt_q.pix + cfg_q.ch_words;
                        cnt_d.addr = cnt_q.pix + cfg_q.ch_words;
                    end else if (cnt_q.ky != cfg_q.k_max) begin
                        cnt_d.ch   = '0;
                        cnt_d.kx   = '0;
                        cnt_d.ky   = cnt_q.ky + ADDR_WIDTH'(1);
                        cnt_d.row  = cnt_q.row + cfg_q.row_words;
                        cnt_d.pix  = cnt_q.row + cfg_q.row_words;
                        cnt_d.addr = cnt_q.row + cfg_q.row_words;
                    end else if (cnt_q.ox != cfg_q.o_max) begin
                        cnt_d.ch   = '0;
                        cnt_d.kx   = '0;
                        cnt_d.ky   = '0;
                        cnt_d.ox   = cnt_q.ox + ADDR_WIDTH'(1);
                        cnt_d.win  = cnt_q.win + cfg_q.stride_words;
                        cnt_d.row  = cnt_q.win + cfg_q.stride_words;
                        cnt_d.pix  = cnt_q.win + cfg_q.stride_words;
                        cnt_d.addr = cnt_q.win + cfg_q.stride_words;
                    end else if (cnt_q.oy != cfg_q.o_max) begin
                        cnt_d.ch   = '0;
                        cnt_d.kx   = '0;
                        cnt_d.ky   = '0;
                        cnt_d.ox   = '0;
                        cnt_d.oy   = cnt_q.oy + ADDR_WIDTH'(1);
                        cnt_d.line = cnt_q.line + cfg_q.line_step;
                        cnt_d.win  = cnt_q.line + cfg_q.line_step;
                        cnt_d.row  = cnt_q.line + cfg_q.line_step;
                        cnt_d.pix  = cnt_q.line + cfg_q.line_step;
                        cnt_d.addr = cnt_q.line + cfg_q.line_step;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end
                end else begin
                    rd_fire_s = 1'b0;
                end
            end
            S_DRAIN: begin
                if ((count_q == '0) && !inflight_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_ERR:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read pipeline tags and output FIFO bookkeeping.
    always_comb begin
        inflight_d = rd_fire_s;
        wl_pipe_d  = rd_fire_s & wl_s;
        fl_pipe_d  = rd_fire_s & fl_s;
        push_s     = inflight_q;
        pop_s      = (count_q != '0) && i_ready;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {fl_pipe_q, wl_pipe_q, i_sram_rd_data};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; the soft clear restores exactly the reset image.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= S_IDLE;
            cfg_q      <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            wl_pipe_q  <= 1'b0;
            fl_pipe_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (i_reg_clear) begin
            state_q    <= S_IDLE;
            cfg_q      <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            wl_pipe_q  <= 1'b0;
            fl_pipe_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            wl_pipe_q  <= wl_pipe_d;
            fl_pipe_q  <= fl_pipe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    // Head entry is masked when empty so stale FIFO contents never leak out.
    assign o_valid      = (count_q != '0);
    assign o_data       = o_valid ? mem_q[rd_ptr_q][DATA_WIDTH-1:0] : '0;
    assign o_win_last   = o_valid & mem_q[rd_ptr_q][DATA_WIDTH];
    assign o_frame_last = o_valid & mem_q[rd_ptr_q][DATA_WIDTH+1];
    assign o_sram_rd_en = rd_fire_s;
    assign o_sram_addr  = rd_fire_s ? cnt_q.addr : '0;
    assign o_busy       = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_ERR);
    assign o_done       = (state_q == S_DONE);
    assign o_cfg_err    = (state_q == S_DONE) && cfg_q.err;

endmodule

// File: tb/tb_window_addr_router.sv
// Bench for window_addr_router: directed and random frames against a nested-loop reference
// model of the window walk, with an SRAM model returning random words.
module tb_window_addr_router;

    localparam int AW = 8;
    localparam int DW = 64;
    localparam int DEPTH = 4;

    logic          clk;
    logic          i_nrst;
    logic          i_reg_clear;
    logic          i_start;
    logic [AW-1:0] i_start_addr, i_i_size, i_o_size, i_stride, i_k_size, i_ch_count;
    logic          o_sram_rd_en;
    logic [AW-1:0] o_sram_addr;
    logic [DW-1:0] i_sram_rd_data;
    logic [DW-1:0] o_data;
    logic          o_valid, i_ready, o_win_last, o_frame_last, o_busy, o_done, o_cfg_err;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sram [256];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wl;
        logic          fl;
    } beat_t;

    window_addr_router #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_nrst(i_nrst), .i_reg_clear(i_reg_clear), .i_start(i_start),
        .i_start_addr(i_start_addr), .i_i_size(i_i_size), .i_o_size(i_o_size),
        .i_stride(i_stride), .i_k_size(i_k_size), .i_ch_count(i_ch_count),
        .o_sram_rd_en(o_sram_rd_en), .o_sram_addr(o_sram_addr),
        .i_sram_rd_data(i_sram_rd_data), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_win_last(o_win_last), .o_frame_last(o_frame_last),
        .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (o_sram_rd_en) i_sram_rd_data <= sram[o_sram_addr];
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_cfg();
        i_start_addr = 8'($urandom);
        i_i_size     = 8'($urandom);
        i_o_size     = 8'($urandom);
        i_stride     = 8'($urandom);
        i_k_size     = 8'($urandom);
        i_ch_count   = 8'($urandom);
    endtask

    // rmode 0: ready always, 1: ready low in cycles 10-19, 2: random ready.
    task automatic run_frame(input int sa, input int isz, input int osz, input int str,
                             input int ksz, input int chc, input int rmode, input int clr_beat);
        beat_t         exp_q[$];
        beat_t         e;
        int            c, beats, issued, done_cnt, first_rd, first_valid, total;
        bit            finished, cleared, prev_stall, r;
        logic [DW-1:0] prev_data;
        logic          prev_wl, prev_fl;
        for (int oy = 0; oy < osz; oy++)
            for (int ox = 0; ox < osz; ox++)
                for (int ky = 0; ky < ksz; ky++)
                    for (int kx = 0; kx < ksz; kx++)
                        for (int ch = 0; ch < chc; ch++) begin
                            e.addr = 8'(sa + ((oy*str + ky)*isz + (ox*str + kx))*chc + ch);
                            e.wl   = (ky == ksz-1) && (kx == ksz-1) && (ch == chc-1);
                            e.fl   = e.wl && (oy == osz-1) && (ox == osz-1);
                            exp_q.push_back(e);
                        end
        total = exp_q.size();
        beats = 0; issued = 0; done_cnt = 0; first_rd = -1; first_valid = -1;
        finished = 0; cleared = 0; prev_stall = 0;
        prev_data = '0; prev_wl = 1'b0; prev_fl = 1'b0;

        @(negedge clk);
        i_start_addr = 8'(sa); i_i_size = 8'(isz); i_o_size = 8'(osz);
        i_stride = 8'(str); i_k_size = 8'(ksz); i_ch_count = 8'(chc);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        scramble_cfg();
        c = 1;
        chk("busy_after_start", o_busy, 1'b1);
        while (!finished && c < 4*total + 100) begin
            case (rmode)
                0:       r = 1'b1;
                1:       r = !(c >= 10 && c <= 19);
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            i_ready = r;
            if (o_sram_rd_en) begin
                chk("credit_limit", (issued - beats < DEPTH), 1'b1);
                if (first_rd < 0) first_rd = c;
                issued++;
            end
            if (prev_stall) begin
                chk("stable_valid", o_valid, 1'b1);
                chk("stable_data", o_data, prev_data);
                chk("stable_tags", {o_win_last, o_frame_last}, {prev_wl, prev_fl});
            end
            if (o_valid && first_valid < 0) first_valid = c;
            if (o_valid && r) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("data_b%0d", beats), o_data, sram[e.addr]);
                    chk($sformatf("win_last_b%0d", beats), o_win_last, e.wl);
                    chk($sformatf("frame_last_b%0d", beats), o_frame_last, e.fl);
                end
                beats++;
            end
            prev_stall = o_valid && !r;
            prev_data = o_data; prev_wl = o_win_last; prev_fl = o_frame_last;
            if (o_done) begin
                done_cnt++;
                chk("cfg_err_clean", o_cfg_err, 1'b0);
                finished = 1;
            end
            if (!finished && clr_beat >= 0 && beats == clr_beat) begin
                i_reg_clear = 1'b1;
                @(negedge clk);
                i_reg_clear = 1'b0;
                chk("clear_valid", o_valid, 1'b0);
                chk("clear_busy", o_busy, 1'b0);
                chk("clear_done", o_done, 1'b0);
                chk("clear_data", o_data, '0);
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    chk("clear_no_done", {o_done, o_sram_rd_en, o_valid}, 3'b000);
                end
                cleared = 1;
                finished = 1;
            end
            if (!finished) begin
                @(negedge clk);
                c++;
            end
        end
        if (!cleared) begin
            chk("frame_done_in_time", finished, 1'b1);
            chk("beat_count", beats, total);
            chk("read_count", issued, total);
            chk("first_rd_cycle", first_rd, 1);
            chk("first_valid_cycle", first_valid, 3);
            chk("done_count", done_cnt, 1);
            @(negedge clk);
            chk("done_pulse_width", o_done, 1'b0);
            chk("idle_busy", o_busy, 1'b0);
        end
        i_ready = 1'b1;
    endtask

    initial begin
        i_nrst = 1'b0; i_reg_clear = 1'b0; i_start = 1'b0; i_ready = 1'b1;
        i_sram_rd_data = '0;
        scramble_cfg();
        for (int a = 0; a < 256; a++) sram[a] = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        chk("reset_outputs", {o_valid, o_sram_rd_en, o_busy, o_done, o_cfg_err,
                              o_win_last, o_frame_last}, 7'b0);
        chk("reset_data", o_data, '0);
        i_nrst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {o_valid, o_busy, o_done}, 3'b000);

        run_frame(0, 5, 3, 1, 3, 1, 0, -1);
        run_frame(0, 5, 2, 2, 3, 1, 0, -1);
        run_frame(16, 4, 2, 1, 3, 2, 0, -1);
        run_frame(0, 5, 3, 1, 3, 1, 1, -1);
        run_frame(0, 5, 3, 1, 3, 1, 0, 20);
        run_frame(0, 5, 3, 1, 3, 1, 0, -1);

        @(negedge clk);
        i_start_addr = 8'd0; i_i_size = 8'd5; i_o_size = 8'd3;
        i_stride = 8'd0; i_k_size = 8'd3; i_ch_count = 8'd1;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("err_c1", {o_done, o_cfg_err, o_sram_rd_en}, 3'b000);
        @(negedge clk);
        chk("err_c2", {o_done, o_cfg_err, o_sram_rd_en}, 3'b110);
        @(negedge clk);
        chk("err_c3", {o_done, o_cfg_err, o_busy}, 3'b000);

        for (int n = 0; n < 6; n++) begin
            run_frame($urandom_range(0, 255), $urandom_range(1, 8), $urandom_range(1, 3),
                      $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
                      2, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
